sme_share_codec: RTL
====================

# sme_share_codec

Serial mask/unmask engine for the SME masked datapath. In MASK mode it converts a plain N-bit word into D Boolean shares using D-1 fresh random words. In UNMASK mode it recombines D shares into the plain word. Folding is one share per cycle, so no single cycle XORs more than two share-derived values. It sits at the boundary between unmasked register-file/load-store data and the masked gadgets, such as the DOM AND, which consume and produce share arrays.

## Interface
Parameters:
- POSEDGE, 1, if 0 all registers trigger on negedge g_clk, else posedge.
- D, 3, number of shares; must be at least 2 (elaboration error otherwise).
- N, 32, word width.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort; returns to IDLE and zeroes all state.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  1  SME_OP_MASK or SME_OP_UNMASK.
- in_data  in  N  plain word (MASK only).
- in_shares  in  N x D (array [SM:0])  share words (UNMASK only).
- rng  in  N x (D-1) (array [D-2:0])  fresh randomness, sampled at accept (MASK only).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  N  plain result; zero unless DONE and op = UNMASK.
- out_shares  out  N x D (array [SM:0])  share result; all zero unless DONE and op = MASK.

## Operation
- State: FSM {IDLE, RUN, DONE}, share register bank sh[0..D-1], op register, fold counter cnt of width clog2(D).
- IDLE: in_ready = 1. On accept:
  - MASK loads sh[0] = in_data and sh[i] = rng[i-1] for i ≥ 1.
  - UNMASK loads sh[i] = in_shares[i].
  - Either mode sets cnt = 1 and enters RUN.
- RUN: each edge does sh[0] ^= sh[cnt] and increments cnt.
  - UNMASK also clears sh[cnt] to 0 in the same edge.
  - When cnt = D-1 on the fold edge, the FSM enters DONE.
- Result values:
  - MASK: sh[0] = x ^ r0 ^ … ^ r(D-2) and sh[i] = r(i-1), so the XOR of all shares equals x.
  - UNMASK: sh[0] = XOR of all input shares, and the other shares are 0.
- DONE: out_valid = 1. Outputs and state hold until out_ready. On the handshake edge, all of sh, op and cnt are zeroed and the FSM returns to IDLE.
- Handshake rules:
  - in_ready is 0 in RUN and DONE; in_valid is ignored there.
  - No accept occurs on the same edge as the DONE handshake.
- flush: takes priority over every other event, including a coincident accept or handshake. Next state is IDLE with sh, op and cnt zeroed, and no out_valid is produced.
- Reset: asynchronous assertion immediately forces IDLE and zeroes sh, op and cnt.
  - Reset values: out_valid = 0, out_data = 0, out_shares all 0, in_ready = 1.
  - Reset mid-RUN or mid-DONE discards the operation.
- Width rules: all XORs are N-bit with no carries. cnt compares against constant D-1.

## Timing
- Accept edge E0; fold edges E1..E(D-1); out_valid is high after E(D-1).
- Latency is D-1 cycles from accept to out_valid (2 for D=3).
- Minimum initiation interval is D+1 cycles: accept, D-1 folds, and the handshake cycle.
- All outputs are registered-state decodes. There are no combinational paths from in_* or rng to out_*, and none from out_ready to in_ready.

## Structure
- sme_pkg holds:
  - SME_OP_MASK = 1'b0 and SME_OP_UNMASK = 1'b1.
  - The codec state enum typedef (IDLE, RUN, DONE).
- Single module. The share bank and FSM are small enough that no sub-module is warranted.
- The POSEDGE generate selects the edge for every register, including the FSM.

## Test plan
- D=3, N=32, MASK of in_data=0xDEADBEEF with rng[0]=0x12345678 and rng[1]=0x0F0F0F0F: out_valid 2 cycles after accept, out_shares = {0xC396E798, 0x12345678, 0x0F0F0F0F}, out_data=0.
- UNMASK of shares {0xC396E798, 0x12345678, 0x0F0F0F0F}: out_data=0xDEADBEEF, out_shares all 0, latency 2.
- Backpressure with out_ready=0 for 5 cycles in DONE: out_valid and out_data stable, in_ready=0, and an in_valid pulse during that time is not accepted.
- flush asserted on fold edge E1: IDLE next cycle, out_valid never rises, internal sh all 0, in_ready=1.
- Asynchronous g_resetn low mid-DONE: out_valid, out_data and out_shares drop to 0 immediately without waiting for a clock edge; operation lost after release.
- Back-to-back, with in_valid and out_ready held 1, alternating MASK/UNMASK over random data: one result every 4 cycles, and UNMASK(MASK(x)) = x for 1000 random x.

Source files
------------

// File: rtl/sme_pkg.sv
// ---------------------------------------------------------------------------
// sme_pkg
// Shared definitions for the SME share codec:
//   - operation encodings for the mask / unmask request
//   - state type of the codec control FSM
// ---------------------------------------------------------------------------
package sme_pkg;

  localparam logic SME_OP_MASK   = 1'b0;
  localparam logic SME_OP_UNMASK = 1'b1;

  typedef enum logic [1:0] {
    SME_ST_IDLE = 2'd0,
    SME_ST_RUN  = 2'd1,
    SME_ST_DONE = 2'd2
  } sme_codec_state_e;

endpackage

// File: rtl/sme_share_codec.sv
// ---------------------------------------------------------------------------
// sme_share_codec
// Serial mask/unmask engine at the boundary between plain data and the
// masked datapath.
//   MASK  : plain word in_data + D-1 random words -> D Boolean shares
//   UNMASK: D shares -> plain word
// The fold runs one share per cycle, so each edge XORs at most two
// share-derived values.
//
// Parameters:
//   POSEDGE  1: registers clock on posedge g_clk, 0: on negedge
//   D        number of shares (>= 2)
//   N        word width
// Ports:
//   g_clk, g_resetn   clock, asynchronous active-low reset
//   flush             synchronous abort, back to IDLE with all state zeroed
//   in_valid/in_ready request handshake; in_op selects MASK / UNMASK
//   in_data           plain word (MASK)
//   in_shares[D-1:0]  share words (UNMASK)
//   rng[D-2:0]        fresh randomness, sampled at accept (MASK)
//   out_valid/out_ready result handshake
//   out_data          plain result, nonzero only in DONE for UNMASK
//   out_shares[D-1:0] share result, nonzero only in DONE for MASK
//
// Handshake semantics (both sides): a transfer happens on the active edge
// where valid & ready are both 1. in_ready is high only in IDLE; out_valid
// is high only in DONE and the result holds until out_ready. Both are pure
// decodes of registered state, so there is no path from out_ready to
// in_ready and no accept can coincide with the result handshake.
// ---------------------------------------------------------------------------
module sme_share_codec
  import sme_pkg::*;
#(
  parameter int POSEDGE = 1,
  parameter int D       = 3,
  parameter int N       = 32
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [N-1:0]           in_data,
  input  logic [D-1:0][N-1:0]    in_shares,
  input  logic [D-2:0][N-1:0]    rng,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [D-1:0][N-1:0]    out_shares
);

  localparam int CW = $clog2(D);

  if (D < 2) begin : g_bad_d
    $error("sme_share_codec: D must be at least 2");
  end

  sme_codec_state_e         state_q, state_d;
  logic [D-1:0][N-1:0]      sh_q, sh_d;
  logic                     op_q, op_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  // Next-state logic. flush overrides every other event.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = SME_ST_IDLE;
      sh_d    = '0;
      op_d    = SME_OP_MASK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SME_ST_IDLE: begin
          if (in_valid) begin
            op_d    = in_op;
            cnt_d   = CW'(1);
            state_d = SME_ST_RUN;
            if (in_op == SME_OP_MASK) begin
              sh_d[0] = in_data;
              for (int i = 1; i < D; i++) begin
                sh_d[i] = rng[i-1];
              end
            end else begin
              sh_d = in_shares;
            end
          end
        end
        SME_ST_RUN: begin
          // Fold share cnt into share 0. For UNMASK the folded share is
          // cleared so only the recombined word remains in the bank.
          for (int i = 1; i < D; i++) begin
            if (cnt_q == CW'(i)) begin
              sh_d[0] = sh_q[0] ^ sh_q[i];
              if (op_q == SME_OP_UNMASK) begin
                sh_d[i] = '0;
              end
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(D - 1)) begin
            state_d = SME_ST_DONE;
          end
        end
        SME_ST_DONE: begin
          if (out_ready) begin
            state_d = SME_ST_IDLE;
            sh_d    = '0;
            op_d    = SME_OP_MASK;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = SME_ST_IDLE;
          sh_d    = '0;
          op_d    = SME_OP_MASK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Edge selection: exactly one of these register blocks is elaborated.
  if (POSEDGE != 0) begin : g_pos
    always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        state_q <= SME_ST_IDLE;
        sh_q    <= '0;
        op_q    <= SME_OP_MASK;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        sh_q    <= sh_d;
        op_q    <= op_d;
        cnt_q   <= cnt_d;
      end
    end
  end else begin : g_neg
    always_ff @(negedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        state_q <= SME_ST_IDLE;
        sh_q    <= '0;
        op_q    <= SME_OP_MASK;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        sh_q    <= sh_d;
        op_q    <= op_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // Output decodes of registered state only; results are gated to zero
  // outside DONE so partially folded shares never leave the block.
  always_comb begin
    in_ready   = (state_q == SME_ST_IDLE);
    out_valid  = (state_q == SME_ST_DONE);
    out_data   = '0;
    out_shares = '0;
    if (state_q == SME_ST_DONE) begin
      if (op_q == SME_OP_UNMASK) begin
        out_data = sh_q[0];
      end else begin
        out_shares = sh_q;
      end
    end
  end

endmodule
